// File: rtl/fnd_pkg.sv
// ============================================================================
// Package : fnd_pkg
// Brief   : Shared constants, state type and helpers for the FND scan capture.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fnd_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int WEIGHT_1000 = 1000;
    localparam int WEIGHT_100  = 100;
    localparam int WEIGHT_10   = 10;
    localparam int WEIGHT_1    = 1;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PUBLISH = 1'b1
    } frame_state_t;

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
        int acc;
        acc = int'(bcd[15:12]) * WEIGHT_1000 + int'(bcd[11:8]) * WEIGHT_100
            + int'(bcd[7:4]) * WEIGHT_10 + int'(bcd[3:0]) * WEIGHT_1;
        return 14'(acc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_seg_decode.sv
// ============================================================================
// Module : fnd_seg_decode
// Brief  : Combinational active-low 7-segment pattern to BCD decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic       blank,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        blank = 1'b0;
        valid = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: begin
                valid = 1'b0;
                blank = 1'b1;
            end
            default:   valid = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_capture.sv
// ============================================================================
// Module : fnd_scan_capture
// Brief  : Captures a scanned 4-digit FND, debounces slots and reports the
//          displayed value. Define FND_DP_EN to also capture decimal points.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_scan_capture
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  fnd_com,
    input  logic [6:0]  fnd_data,
`ifdef FND_DP_EN
    input  logic        fnd_dp,
    output logic [3:0]  dp_mask,
`endif
    input  logic        err_clr,
    output logic [13:0] value,
    output logic [15:0] digits,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        changed,
    output logic        err_seg,
    output logic        err_com,
    output logic        stalled
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]    r_com, r_com_prev;
    logic [6:0]    r_data, r_data_prev;
    logic [SW-1:0] r_settle;
    logic [TW-1:0] r_tmo;
    logic [3:0]    r_seen;
    logic [15:0]   r_dig_buf;
    logic [3:0]    r_blank_buf;
    logic          r_have_frame;
    frame_state_t  r_state;

    logic          w_com_change, w_any_change, w_sample, w_tmo_hit;
    logic          w_one_low, w_multi_low;
    logic          w_blank, w_valid;
    logic [3:0]    w_bcd, w_sel, w_seen_next;
    logic [13:0]   w_new_value;

`ifdef FND_DP_EN
    logic          r_dp, r_dp_prev;
    logic [3:0]    r_dp_buf;
    assign w_any_change = w_com_change || (r_data != r_data_prev) || (r_dp != r_dp_prev);
`else
    assign w_any_change = w_com_change || (r_data != r_data_prev);
`endif

    assign w_com_change = (r_com != r_com_prev);
    assign w_sample     = !w_any_change && (r_settle == SW'(SETTLE_CYC - 1));
    assign w_tmo_hit    = !w_com_change && (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_one_low    = ($countones(~r_com) == 1);
    assign w_multi_low  = ($countones(~r_com) > 1);
    assign w_sel        = ~r_com;
    assign w_seen_next  = r_seen | w_sel;
    assign w_new_value  = bcd_to_bin(r_dig_buf);

    fnd_seg_decode u_dec (
        .seg   (r_data),
        .blank (w_blank),
        .valid (w_valid),
        .bcd   (w_bcd)
    );

    // Input registers, the previous copy for change detection, and the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_com       <= 4'hF;
            r_com_prev  <= 4'hF;
            r_data      <= 7'h7F;
            r_data_prev <= 7'h7F;
`ifdef FND_DP_EN
            r_dp        <= 1'b1;
            r_dp_prev   <= 1'b1;
`endif
            r_settle    <= '0;
            r_tmo       <= '0;
            stalled     <= 1'b0;
        end else begin
            r_com       <= fnd_com;
            r_com_prev  <= r_com;
            r_data      <= fnd_data;
            r_data_prev <= r_data;
`ifdef FND_DP_EN
            r_dp        <= fnd_dp;
            r_dp_prev   <= r_dp;
`endif
            if (w_any_change)
                r_settle <= '0;
            else if (r_settle != SW'(SETTLE_CYC))
                r_settle <= r_settle + 1'b1;

            if (w_com_change)
                r_tmo <= '0;
            else if (r_tmo != TW'(TIMEOUT_CYC))
                r_tmo <= r_tmo + 1'b1;

            if (w_com_change)
                stalled <= 1'b0;
            else if (w_tmo_hit)
                stalled <= 1'b1;
        end
    end

    // Slot buffer and frame FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_COLLECT;
            r_seen       <= 4'h0;
            r_dig_buf    <= 16'h0;
            r_blank_buf  <= 4'h0;
            r_have_frame <= 1'b0;
            value        <= 14'd0;
            digits       <= 16'h0;
            blank_mask   <= 4'h0;
            frame_valid  <= 1'b0;
            changed      <= 1'b0;
            err_seg      <= 1'b0;
            err_com      <= 1'b0;
`ifdef FND_DP_EN
            r_dp_buf     <= 4'h0;
            dp_mask      <= 4'h0;
`endif
        end else begin
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            err_seg     <= (err_seg && !err_clr) || (w_sample && w_one_low && !w_valid && !w_blank);
            err_com     <= (err_com && !err_clr) || (w_sample && w_multi_low);

            case (r_state)
                ST_COLLECT: begin
                    if (w_sample && w_one_low && (w_valid || w_blank)) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (w_sel[i]) begin
                                r_dig_buf[i*4 +: 4] <= w_bcd;
                                r_blank_buf[i]      <= w_blank;
`ifdef FND_DP_EN
                                r_dp_buf[i]         <= !r_dp;
`endif
                            end
                        end
                        r_seen <= w_seen_next;
                        if (w_seen_next == 4'hF)
                            r_state <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    value        <= w_new_value;
                    digits       <= r_dig_buf;
                    blank_mask   <= r_blank_buf;
`ifdef FND_DP_EN
                    dp_mask      <= r_dp_buf;
`endif
                    frame_valid  <= 1'b1;
                    changed      <= !r_have_frame || (w_new_value != value);
                    r_have_frame <= 1'b1;
                    r_seen       <= 4'h0;
                    r_state      <= ST_COLLECT;
                end
                default: r_state <= ST_COLLECT;
            endcase

            // A stalled scan abandons any partially collected frame
            if (w_tmo_hit)
                r_seen <= 4'h0;
        end
    end

endmodule

`default_nettype wire

// File: doc/fnd_scan_capture.md
Name: fnd_scan_capture

Overview:
- Receiving end of the 4-digit multiplexed FND interface (fnd_com/fnd_data) driven by the display counters.
- Watches the scanned digit-select and segment lines, debounces each digit slot, and decodes segment patterns back to BCD.
- Assembles complete scan frames and reports the displayed value as binary 0..9999.
- Used as an on-chip display monitor/self-check and as a bench-reusable capture block.

Parameters:
- SETTLE_CYC, 4: consecutive cycles that fnd_com and fnd_data must hold unchanged before a digit is sampled.
- TIMEOUT_CYC, 4096: cycles with no fnd_com change before the scan is declared stalled.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- fnd_com  in  4  digit select, active-low; bit0 = ones digit … bit3 = thousands digit
- fnd_data  in  7  segments, active-low; bit0 = a … bit6 = g
- err_clr  in  1  synchronous clear of the sticky error flags
- value  out  14  last complete frame value, binary, 0..9999
- digits  out  16  last complete frame as BCD, {d3,d2,d1,d0}
- blank_mask  out  4  digit slots that were blank (all segments off) in the last frame
- frame_valid  out  1  one-cycle pulse when value, digits and blank_mask update
- changed  out  1  one-cycle pulse with frame_valid when value differs from the previous frame
- err_seg  out  1  sticky: undecodable segment pattern sampled
- err_com  out  1  sticky: more than one fnd_com bit low while stable
- stalled  out  1  level: scan timeout active

Behaviour:
- Reset values (async, rst=0): all outputs 0, seen bits 0, settle and timeout counters 0, input registers reset to 4'hF / 7'h7F.
- Inputs are registered once; all logic below uses the registered copies.
- Settle counter:
  - Resets to 0 on any change of {fnd_com, fnd_data}; otherwise increments, saturating at SETTLE_CYC.
  - A sample fires exactly once, on the cycle the counter reaches SETTLE_CYC.
- Sample with fnd_com == 4'hF (all off): ignored.
- Sample with exactly one fnd_com bit low (slot k):
  - Decode fnd_data. Valid digit → store BCD in slot k, clear blank bit k.
  - 7'h7F → store 0 in slot k, set blank bit k.
  - Any other pattern → set err_seg; slot k is not marked seen.
  - Otherwise set seen[k]. A repeated slot before frame completion overwrites the stored digit (latest wins).
- Sample with two or more fnd_com bits low: set err_com; nothing stored.
- Frame completion:
  - When seen == 4'hF after a sample, the next cycle registers value = d3*1000 + d2*100 + d1*10 + d0, plus digits and blank_mask.
  - frame_valid pulses on that cycle; seen clears on the same cycle.
  - changed pulses on that cycle if the new value differs from the held value. The first frame after reset always asserts changed.
- Latency: last digit's settle-complete cycle + 1 to frame_valid.
- Timeout:
  - Counter resets on any fnd_com change.
  - On reaching TIMEOUT_CYC, stalled=1, seen clears, and the counter holds.
  - stalled drops on the next fnd_com change. value is held throughout.
- err_clr clears err_seg and err_com. If an error event occurs in the same cycle as err_clr, the flag stays set (set wins).
- Reset mid-frame discards partial seen/digit state.

Optional Feature:
- FND_DP_EN defined:
  - Adds input fnd_dp (1, active-low) and output dp_mask (4).
  - The dp state is captured per slot alongside the digit and published with frame_valid.
  - fnd_dp is included in the settle-change comparison.
- FND_DP_EN undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package fnd_pkg:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK (active-low, a = bit0).
  - NUM_DIGITS = 4.
  - Digit-weight constants 1000/100/10/1.
- Sub-module fnd_seg_decode: combinational 7-bit pattern → {blank, valid, bcd[3:0]}.
- Settle/timeout counters, slot buffer, and frame FSM stay in the top module.

Test Plan:
- Scan "1234" (digit select, 100 cycles per digit, order ones→thousands, patterns per fnd_pkg), run 3 frames → frame_valid every 400 cycles, value=1234, digits=16'h1234, changed only on the first frame.
- Scan with thousands and hundreds blank, showing "  42" → value=42, blank_mask=4'b1100.
- Value steps 0999 → 1000 between frames → changed pulses once, value=1000.
- Segment glitch shorter than SETTLE_CYC mid-digit → no sample and no error, value unchanged. Hold pattern 7'h00 (all segments on, i.e. "8") on a slot → decodes as 8. Hold 7'h55 → err_seg=1; err_clr → 0.
- fnd_com=4'b1100 held for 10 cycles → err_com=1, no frame. Freeze the scan for TIMEOUT_CYC cycles → stalled=1. Resume the scan → stalled=0, the next full frame reports the correct value.
- Assert rst after 2 digits of a frame → all outputs 0. The first frame after release requires all 4 slots.
